// File: rtl/wsg_audio_pkg.sv
// Shared types and constants for the WSG-to-HDMI audio sample path.
package wsg_audio_pkg;

  localparam int unsigned WSG_IN_WIDTH    = 10;
  localparam int unsigned HDMI_OUT_WIDTH  = 16;
  localparam int unsigned WSG_SAMPLE_RATE = 24000;
  localparam int unsigned HDMI_AUDIO_RATE = 48000;

  typedef logic signed [WSG_IN_WIDTH-1:0]   wsg_sample_t;
  typedef logic signed [HDMI_OUT_WIDTH-1:0] hdmi_sample_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } bridge_state_t;

endpackage

// File: rtl/wsg_sample_fifo.sv
// Small circular-buffer FIFO with head peek; pointers wrap naturally (power-of-two depth).
module wsg_sample_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_pixel,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_c, do_pop_c;

  // Full/empty are judged on the occupancy before this cycle's push/pop.
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    empty_c   = (count_q == '0);
    do_push_c = push_i & ~full_c;
    do_pop_c  = pop_i & ~empty_c;
    head_c    = mem_q[rd_ptr_q];
    fill_o    = count_q;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sample storage; only entries below the occupancy are ever read.
  always_ff @(posedge clk_pixel) begin
    if (do_push_c) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wsg_audio_bridge.sv
// WSG mix sample -> HDMI audio word bridge: FIFO buffering, 2x upsampling on
// clk_audio falling edges, sticky overflow/underflow flags.
// Build option: define WSG_AUDIO_INTERP_EN for linear interpolation on odd
// phases; otherwise odd phases repeat the current sample.
module wsg_audio_bridge
  import wsg_audio_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = WSG_IN_WIDTH,
  parameter int unsigned OUT_WIDTH   = HDMI_OUT_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PRIME_LEVEL = 2
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic                          clk_audio,
  input  logic [IN_WIDTH-1:0]           sample_in,
  input  logic                          sample_valid,
  input  logic                          clear_flags,
  output logic [OUT_WIDTH-1:0]          sample_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SHIFT  = OUT_WIDTH - IN_WIDTH;

  bridge_state_t               state_q, state_d;
  logic                        phase_q, phase_d;
  logic signed [IN_WIDTH-1:0]  cur_q, cur_d;
  logic [OUT_WIDTH-1:0]        sample_out_q, sample_out_d;
  logic                        overflow_q, overflow_d;
  logic                        underflow_q, underflow_d;
  logic                        clk_audio_q;
  logic                        tick_c, pop_c, full_c, empty_c;
  logic [IN_WIDTH-1:0]         head_c;

  function automatic logic [OUT_WIDTH-1:0] scale(input logic signed [IN_WIDTH-1:0] x);
    return OUT_WIDTH'(x) <<< SHIFT;
  endfunction

  wsg_sample_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .push_i    (sample_valid),
    .data_i    (sample_in),
    .pop_i     (pop_c),
    .head_c    (head_c),
    .fill_o    (fill),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  assign tick_c = clk_audio_q & ~clk_audio;

`ifdef WSG_AUDIO_INTERP_EN
  logic signed [IN_WIDTH:0]   sum_c;
  logic signed [IN_WIDTH-1:0] avg_c;

  // Floor average of current sample and FIFO head (arithmetic shift rounds toward -inf).
  always_comb begin
    sum_c = (IN_WIDTH+1)'(cur_q) + (IN_WIDTH+1)'($signed(head_c));
    avg_c = IN_WIDTH'(sum_c >>> 1);
  end
`endif

  // Next-state, pop request, output word and sticky flags.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cur_d        = cur_q;
    sample_out_d = sample_out_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    pop_c        = 1'b0;

    if (clear_flags) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (sample_valid && full_c) overflow_d = 1'b1;

    case (state_q)
      PRIME: begin
        sample_out_d = '0;
        if (tick_c && (fill >= FILL_W'(PRIME_LEVEL))) begin
          pop_c   = 1'b1;
          cur_d   = $signed(head_c);
          phase_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick_c) begin
          if (!phase_q) begin
            sample_out_d = scale(cur_q);
            phase_d      = 1'b1;
          end else if (!empty_c) begin
`ifdef WSG_AUDIO_INTERP_EN
            sample_out_d = scale(avg_c);
`else
            sample_out_d = scale(cur_q);
`endif
            pop_c        = 1'b1;
            cur_d        = $signed(head_c);
            phase_d      = 1'b0;
          end else begin
            sample_out_d = scale(cur_q);
            underflow_d  = 1'b1;
            phase_d      = 1'b0;
          end
        end
      end
      default: state_d = PRIME;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PRIME;
      phase_q      <= 1'b0;
      cur_q        <= '0;
      sample_out_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      clk_audio_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cur_q        <= cur_d;
      sample_out_q <= sample_out_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      clk_audio_q  <= clk_audio;
    end
  end

  assign sample_out = sample_out_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_wsg_audio_bridge.sv
// Scoreboard bench for wsg_audio_bridge: a queue-based reference model predicts
// each tick's output word; an independent monitor checks it after the tick edge.
module tb_wsg_audio_bridge;

  localparam int DEPTH = 4;
  localparam int PRIME = 2;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic        clk_audio = 1'b0;
  logic [9:0]  sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        clear_flags  = 1'b0;
  logic [15:0] sample_out;
  logic [2:0]  fill;
  logic        overflow, underflow;

  wsg_audio_bridge dut (
    .clk_pixel    (clk_pixel),
    .reset_n      (reset_n),
    .clk_audio    (clk_audio),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .sample_out   (sample_out),
    .fill         (fill),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_q[$];
  bit          m_primed, m_phase, m_ovf, m_unf, m_aud_prev;
  int          m_cur, m_out;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int avg_floor(input int a, input int b);
    int s;
    s = a + b;
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_primed = 0; m_phase = 0; m_ovf = 0; m_unf = 0; m_aud_prev = 0;
    m_cur = 0; m_out = 0;
  endtask

  // One clk_pixel cycle of spec behaviour: tick acts on pre-push contents.
  task automatic model_cycle(input bit v, input logic [9:0] d, input bit a, input bit c);
    bit tick, full_before, set_unf;
    int val;
    tick        = m_aud_prev && !a;
    m_aud_prev  = a;
    full_before = (m_q.size() == DEPTH);
    set_unf     = 0;
    if (tick) begin
      if (!m_primed) begin
        if (m_q.size() >= PRIME) begin
          m_cur = m_q.pop_front(); m_primed = 1; m_phase = 0;
        end
      end else if (!m_phase) begin
        m_out = m_cur * 64; m_phase = 1;
      end else if (m_q.size() > 0) begin
`ifdef WSG_AUDIO_INTERP_EN
        m_out = avg_floor(m_cur, m_q[0]) * 64;
`else
        m_out = m_cur * 64;
`endif
        m_cur = m_q.pop_front(); m_phase = 0;
      end else begin
        m_out = m_cur * 64; set_unf = 1; m_phase = 0;
      end
      exp_q.push_back(16'(m_out));
    end
    if (v && !full_before) begin
      val = int'($signed(d));
      m_q.push_back(val);
    end
    if (c) begin m_ovf = 0; m_unf = 0; end
    if (v && full_before) m_ovf = 1;
    if (set_unf) m_unf = 1;
  endtask

  // Drive one cycle of inputs at the falling edge, check status after the rising edge.
  task automatic step(input bit v, input logic [9:0] d, input bit a, input bit c);
    @(negedge clk_pixel);
    sample_valid = v; sample_in = d; clk_audio = a; clear_flags = c;
    model_cycle(v, d, a, c);
    @(posedge clk_pixel); #1;
    chk("fill", int'(fill), m_q.size());
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
  endtask

  task automatic run_audio(input int n_ticks, input int half);
    for (int t = 0; t < n_ticks; t++) begin
      repeat (half) step(0, '0, 1, 0);
      repeat (half) step(0, '0, 0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    reset_n = 1'b0;
    sample_valid = 0; clear_flags = 0; clk_audio = 0;
    #1;
    chk("reset_async_out", int'(sample_out), 0);
    model_reset();
    repeat (2) @(negedge clk_pixel);
    chk("reset_fill", int'(fill), 0);
    chk("reset_flags", int'({overflow, underflow}), 0);
    reset_n = 1'b1;
  endtask

  // Monitor: detect ticks the same way the bridge sees clk_audio, then compare.
  initial begin : monitor
    bit prev, tk;
    logic [15:0] e;
    prev = 0;
    forever begin
      @(posedge clk_pixel);
      if (!reset_n) begin
        prev = 0;
      end else begin
        tk   = prev && !clk_audio;
        prev = clk_audio;
        if (tk) begin
          #1;
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sample_out: got 0x%0h with no expected value queued", sample_out);
          end else begin
            e = exp_q.pop_front();
            chk("sample_out", int'(sample_out), int'(e));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int half, pmod, cnt;
    bit lvl;
    model_reset();
    #1;
    chk("reset_out", int'(sample_out), 0);
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;

    // Priming threshold and interpolation sequence
    step(1, 10'h040, 0, 0);
    run_audio(1, 4);
    chk("prime_hold_out", int'(sample_out), 0);
    step(1, 10'h080, 0, 0);
    run_audio(1, 4);
    step(1, 10'h0C0, 0, 0);
    run_audio(4, 4);
`ifdef WSG_AUDIO_INTERP_EN
    chk("interp_last", int'(sample_out), 16'h2800);
`else
    chk("interp_last", int'(sample_out), 16'h2000);
`endif
    run_audio(2, 4);
    chk("underflow_hold_out", int'(sample_out), 16'h3000);
    chk("underflow_set", int'(underflow), 1);

    // Negative rounding: avg(-3, 0) = -2
    do_reset();
    step(1, 10'h3FD, 0, 0);
    step(1, 10'h000, 0, 0);
    run_audio(3, 4);
`ifdef WSG_AUDIO_INTERP_EN
    chk("neg_round", int'(sample_out), 16'hFF80);
`else
    chk("neg_round", int'(sample_out), 16'hFF40);
`endif

    // Overflow: five pushes, no ticks
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 10'(i * 8), 0, 0);
    chk("ovf_fill", int'(fill), 4);
    chk("ovf_flag", int'(overflow), 1);
    step(0, '0, 0, 1);
    chk("ovf_clear", int'(overflow), 0);
    run_audio(12, 3);

    // Push in the same cycle as a popping tick
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 10'(100 + i), 0, 0);
    run_audio(2, 4);
    repeat (4) step(0, '0, 1, 0);
    step(1, 10'h155, 0, 0);
    chk("push_pop_fill", int'(fill), 2);
    repeat (3) step(0, '0, 0, 0);

    // Randomized segments at varying push rates, with a reset mid-stream
    for (int seg = 0; seg < 3; seg++) begin
      half = 3 + seg;
      pmod = (seg == 0) ? 5 : (seg == 1) ? 20 : 4 * half;
      lvl  = clk_audio;
      cnt  = 0;
      for (int c = 0; c < 900; c++) begin
        if (cnt == half) begin lvl = !lvl; cnt = 0; end
        cnt++;
        step($urandom_range(0, pmod - 1) == 0, 10'($urandom_range(0, 1023)),
             lvl, $urandom_range(0, 63) == 0);
      end
      if (seg == 1) do_reset();
    end

    repeat (4) step(0, '0, 0, 0);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
